// File: rtl/sine_quarter_reader.sv
// Full-wave sine sample generator driven by a quarter-wave magnitude ROM.
// A phase accumulator selects quadrant and ROM index; the sample is held until accepted downstream.
module sine_quarter_reader #(
    parameter int ROM_DEPTH = 64,
    parameter int ROM_WIDTH = 8,
    parameter int PHASEW    = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [PHASEW-1:0]            step,
    output logic [$clog2(ROM_DEPTH)-1:0] rom_addr,
    input  logic [ROM_WIDTH-1:0]         rom_data,
    output logic [2*ROM_WIDTH-1:0]       sample,
    output logic                         sample_valid,
    input  logic                         sample_ready
);

    localparam int ADDRW = $clog2(4 * ROM_DEPTH);
    localparam int AW    = $clog2(ROM_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        CAPTURE,
        HOLD
    } state_t;

    state_t                   state_q;
    logic [PHASEW-1:0]        phase_q;
    logic [AW-1:0]            rom_addr_q;
    logic                     neg_q;
    logic [2*ROM_WIDTH-1:0]   sample_q;
    logic                     sample_valid_q;

    logic [ADDRW-1:0]         idx;
    logic [AW-1:0]            low;
    logic [AW-1:0]            rom_addr_d;
    logic [2*ROM_WIDTH-1:0]   mag;
    logic [2*ROM_WIDTH-1:0]   sample_d;

    assign idx = phase_q[PHASEW-1 -: ADDRW];
    assign low = idx[AW-1:0];

    // With a power-of-two depth, DEPTH-1-low is the bitwise complement of low,
    // so odd quadrants mirror the table by inverting each address bit.
    genvar gi;
    generate
        for (gi = 0; gi < AW; gi++) begin : g_mirror
            assign rom_addr_d[gi] = low[gi] ^ idx[ADDRW-2];
        end
    endgenerate

    assign mag      = {{ROM_WIDTH{1'b0}}, rom_data};
    assign sample_d = neg_q ? -mag : mag;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            phase_q        <= '0;
            rom_addr_q     <= '0;
            neg_q          <= 1'b0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en) begin
                        state_q <= ADDR;
                    end
                end
                ADDR: begin
                    rom_addr_q <= rom_addr_d;
                    neg_q      <= idx[ADDRW-1];
                    state_q    <= CAPTURE;
                end
                CAPTURE: begin
                    sample_q       <= sample_d;
                    sample_valid_q <= 1'b1;
                    phase_q        <= phase_q + step;
                    state_q        <= HOLD;
                end
                HOLD: begin
                    if (sample_valid_q && sample_ready) begin
                        sample_valid_q <= 1'b0;
                        state_q        <= en ? ADDR : IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rom_addr     = rom_addr_q;
    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;

endmodule

// File: doc/sine_quarter_reader.md
SINE_QUARTER_READER -- requirements
Module: sine_quarter_reader

Interface
REQ-001 Parameter ROM_DEPTH, default 64, entries in the external quarter-wave magnitude ROM (power of two, >=4).
REQ-002 Parameter ROM_WIDTH, default 8, ROM word width (unsigned magnitude).
REQ-003 Parameter PHASEW, default 16, phase accumulator width; SHALL be >= ADDRW, where ADDRW = clog2(4*ROM_DEPTH).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 en  input  1  run request; level-sensitive.
REQ-007 step  input  PHASEW  phase increment per generated sample; sampled in CAPTURE.
REQ-008 rom_addr  output  clog2(ROM_DEPTH)  registered read address to the asynchronous ROM.
REQ-009 rom_data  input  ROM_WIDTH  ROM word, combinationally valid one cycle after rom_addr changes.
REQ-010 sample  output  2*ROM_WIDTH  signed full-wave sine sample, registered.
REQ-011 sample_valid  output  1  sample holds a new value.
REQ-012 sample_ready  input  1  downstream accepts sample when high together with sample_valid.

Function
REQ-013 FSM states: IDLE, ADDR, CAPTURE, HOLD.
REQ-014 IDLE: sample_valid=0; en=1 -> ADDR; otherwise stay.
REQ-015 ADDR (one cycle): idx = phase[PHASEW-1 -: ADDRW]; quadrant q = idx[ADDRW-1:ADDRW-2]; low = idx[ADDRW-3:0]; rom_addr <= q[0] ? (ROM_DEPTH-1-low) : low; neg <= q[1]; -> CAPTURE.
REQ-016 CAPTURE (one cycle): mag = rom_data zero-extended to 2*ROM_WIDTH; sample <= neg ? -mag : mag (two's complement); sample_valid <= 1; phase <= phase + step (modulo 2^PHASEW, wrap silently); -> HOLD.
REQ-017 HOLD: sample and sample_valid stable until sample_valid && sample_ready; on that edge sample_valid <= 0 and next state = en ? ADDR : IDLE.
REQ-018 sample_ready is ignored in all states other than HOLD.
REQ-019 Latency: en rising in IDLE -> sample_valid high 3 edges later; with sample_ready held high, one sample every 3 cycles.
REQ-020 en deasserted in ADDR/CAPTURE/HOLD: current sample completes and is held until accepted, then IDLE; phase is retained (no reset) across IDLE.
REQ-021 step=0: identical samples repeat indefinitely.
REQ-022 Negation of mag never overflows (|mag| <= 2^ROM_WIDTH-1 within 2*ROM_WIDTH signed range).
REQ-023 rom_addr changes only in ADDR.

Reset
REQ-024 rst=1 at any edge, in any state: state <= IDLE, phase <= 0, rom_addr <= 0, neg <= 0, sample <= 0, sample_valid <= 0; rst dominates en and sample_ready.
REQ-025 Reset mid-HOLD discards the pending sample; no acceptance occurs on the reset edge.

Verification
(ROM model for all scenarios: rom_data = rom_addr + 1, defaults, step = 2^(PHASEW-ADDRW) = 256 so idx advances by 1 per sample, sample_ready=1 unless stated.)
REQ-026 rst, then en=1 -> first sample_valid 3 cycles after en, sample=16'h0001 (idx 0, addr 0); second sample 3 cycles later =16'h0002.
REQ-027 Run 256 samples -> idx 64 gives addr 63, sample=64; idx 127 gives addr 0, sample=1; idx 130 gives addr 2, sample=16'hFFFD; idx 255 gives addr 0, sample=16'hFFFF; idx 256 wraps to idx 0, sample=1.
REQ-028 sample_ready=0 for 10 cycles in HOLD -> sample and sample_valid unchanged, rom_addr unchanged; ready=1 -> accepted on one edge only, next sample follows 3 cycles later.
REQ-029 en dropped during CAPTURE -> sample delivered and accepted, FSM to IDLE, sample_valid=0; en re-raised -> next sample continues from retained phase (no restart at idx 0).
REQ-030 rst asserted in HOLD with sample_ready=0 -> next edge: sample_valid=0, sample=0, rom_addr=0, phase=0; after release and en=1 first sample=16'h0001.
REQ-031 step=0 after reset -> every accepted sample equals 16'h0001.
